ob_writeback: RTL

Drain stage directly downstream of the output buffer. Accepts one full result window (QUEUE_NUM rows × QUEUE_LEN accumulator values) per valid/ready handshake. Requantizes each value with rounding right shift, optional ReLU and saturation. Emits the values one per cycle as addressed writes to the output memory, for a programmed number of windows per job.

---
 rtl/ob_writeback_if.sv | 27 ++
 rtl/ob_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ob_writeback_if.sv
// Window/write bus between the output buffer, the writeback drain and the output memory.
// master = drain side (accepts windows, issues writes); slave = surrounding environment.
interface ob_writeback_if #(
    parameter int unsigned QUEUE_NUM  = 1,
    parameter int unsigned QUEUE_LEN  = 3,
    parameter int unsigned C_WIDTH    = 16,
    parameter int unsigned O_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic                                            i_pre_valid;
    logic                                            o_pre_ready;
    logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][C_WIDTH-1:0] i_data;
    logic                                            o_wr_en;
    logic [ADDR_WIDTH-1:0]                           o_wr_addr;
    logic [O_WIDTH-1:0]                              o_wr_data;
    logic                                            i_wr_ready;

    modport master (
        input  i_pre_valid, i_data, i_wr_ready,
        output o_pre_ready, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_pre_valid, i_data, i_wr_ready,
        input  o_pre_ready, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/ob_writeback.sv
// Output-buffer drain: takes one result window per handshake, requantizes each value
// (rounding shift, optional ReLU, saturation) and writes them one per cycle to memory.
module ob_writeback #(
    parameter int unsigned QUEUE_NUM  = 1,
    parameter int unsigned QUEUE_LEN  = 3,
    parameter int unsigned C_WIDTH    = 16,
    parameter int unsigned O_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_win_num,
    input  logic [3:0]            i_shift,
    input  logic                  i_relu_en,
    ob_writeback_if.master        bus,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned N_ELEM  = QUEUE_NUM * QUEUE_LEN;
    localparam int unsigned K_WIDTH = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned V_WIDTH = C_WIDTH + 1;

    localparam logic [K_WIDTH-1:0]        K_LAST  = K_WIDTH'(N_ELEM - 1);
    localparam logic signed [V_WIDTH-1:0] SAT_MAX = V_WIDTH'((1 << (O_WIDTH - 1)) - 1);
    localparam logic signed [V_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Flat view of a window: element k = row k/QUEUE_LEN, column k%QUEUE_LEN.
    typedef logic [N_ELEM-1:0][C_WIDTH-1:0] win_t;

    state_t                r_state;
    state_t                w_state_nxt;

    win_t                  w_in_flat;
    win_t                  r_win;
    logic [CNT_WIDTH-1:0]  r_win_num;
    logic [CNT_WIDTH-1:0]  r_win_idx;
    logic [3:0]            r_shift;
    logic                  r_relu;
    logic [K_WIDTH-1:0]    r_k;

    logic                  r_pre_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [O_WIDTH-1:0]    r_wr_data;
    logic                  r_busy;
    logic                  r_done;

    logic [K_WIDTH-1:0]    w_k_nxt;
    logic [K_WIDTH-1:0]    w_k_inc;
    logic [CNT_WIDTH-1:0]  w_win_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [O_WIDTH-1:0]    w_data_nxt;
    logic                  w_load_job;
    logic                  w_load_win;
    logic                  w_last_win;

    assign w_in_flat  = bus.i_data;
    assign w_k_inc    = r_k + K_WIDTH'(1);
    assign w_last_win = (r_win_idx == (r_win_num - CNT_WIDTH'(1)));

    // Round-half-up shift, ReLU and saturation; one extra bit keeps x + rounding exact.
    function automatic logic [O_WIDTH-1:0] requant(
        input logic [C_WIDTH-1:0] x,
        input logic [3:0]         sh,
        input logic               relu
    );
        logic signed [V_WIDTH-1:0] v;
        logic signed [V_WIDTH-1:0] rnd;
        rnd = '0;
        if (sh != 4'd0) begin
            rnd = V_WIDTH'(1) << (sh - 4'd1);
        end
        v = $signed({x[C_WIDTH-1], x}) + rnd;
        v = v >>> sh;
        if (relu && v[V_WIDTH-1]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[O_WIDTH-1:0];
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the counters and write port.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_win_idx_nxt = r_win_idx;
        w_addr_nxt    = r_wr_addr;
        w_data_nxt    = r_wr_data;
        w_load_job    = 1'b0;
        w_load_win    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load_job    = 1'b1;
                    w_addr_nxt    = i_base_addr;
                    w_win_idx_nxt = '0;
                    w_k_nxt       = '0;
                    w_state_nxt   = (i_win_num != '0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (bus.i_pre_valid && r_pre_ready) begin
                    w_load_win  = 1'b1;
                    w_k_nxt     = '0;
                    w_data_nxt  = requant(w_in_flat[0], r_shift, r_relu);
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.i_wr_ready) begin
                    // Addresses are contiguous across windows, so the port just counts up.
                    w_addr_nxt = r_wr_addr + ADDR_WIDTH'(1);
                    if (r_k == K_LAST) begin
                        w_k_nxt = '0;
                        if (w_last_win) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_win_idx_nxt = r_win_idx + CNT_WIDTH'(1);
                            w_state_nxt   = S_WAIT;
                        end
                    end else begin
                        w_k_nxt    = w_k_inc;
                        w_data_nxt = requant(r_win[w_k_inc], r_shift, r_relu);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job parameters, window storage, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win       <= '0;
            r_win_num   <= '0;
            r_win_idx   <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_k         <= '0;
            r_pre_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_load_job) begin
                r_win_num <= i_win_num;
                r_shift   <= i_shift;
                r_relu    <= i_relu_en;
            end
            if (w_load_win) begin
                r_win <= w_in_flat;
            end
            r_win_idx   <= w_win_idx_nxt;
            r_k         <= w_k_nxt;
            r_wr_addr   <= w_addr_nxt;
            r_wr_data   <= w_data_nxt;
            r_pre_ready <= (w_state_nxt == S_WAIT);
            r_wr_en     <= (w_state_nxt == S_WRITE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.o_pre_ready = r_pre_ready;
    assign bus.o_wr_en     = r_wr_en;
    assign bus.o_wr_addr   = r_wr_addr;
    assign bus.o_wr_data   = r_wr_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule
